// File: rtl/ps2_keyboard_rx_pkg.sv
// ps2_keyboard_rx_pkg: shared defaults and frame constants for the PS/2 receiver
package ps2_keyboard_rx_pkg;
    localparam int PS2_FIFO_AW = 3;
    localparam int PS2_SYNC_LEN = 3;
    localparam int PS2_FRAME_LEN = 11;
    localparam int PS2_STOP_IDX = PS2_FRAME_LEN - 1;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: circular scan-code buffer with one slot kept empty and a sticky overflow flag
module ps2_rx_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       ready,
    output logic       overflow
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full;

    assign full  = (wr_ptr + AW'(1)) == rd_ptr;
    assign ready = wr_ptr != rd_ptr;
    assign dout  = mem[rd_ptr];

    // write on push when space remains, flag a drop when full, advance head on pop
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 2**AW; i++) mem[i] <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (push && full) overflow <= 1'b1;
            if (pop && ready) rd_ptr <= rd_ptr + AW'(1);
        end
    end
endmodule

// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 deframer feeding a scan-code FIFO; PS2_PARITY_CHECK_EN enables odd-parity check
module ps2_keyboard_rx
    import ps2_keyboard_rx_pkg::*;
#(
    parameter int FIFO_AW  = PS2_FIFO_AW,
    parameter int SYNC_LEN = PS2_SYNC_LEN
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow
);
`ifdef PS2_PARITY_CHECK_EN
    localparam int BUF_W = 10;
`else
    localparam int BUF_W = 9;
`endif

    logic [SYNC_LEN-1:0] clk_sync;
    logic [3:0]          cnt;
    logic [BUF_W-1:0]    buffer;
    logic [1:0]          nd_sync;
    logic                fall, frame_ok, push, pop;

    assign fall = clk_sync[SYNC_LEN-1] & ~clk_sync[SYNC_LEN-2];
`ifdef PS2_PARITY_CHECK_EN
    assign frame_ok = ~buffer[0] & ps2_data & (^buffer[9:1]);
`else
    assign frame_ok = ~buffer[0] & ps2_data;
`endif
    assign push = fall & (cnt == 4'(PS2_STOP_IDX)) & frame_ok;
    assign pop  = nd_sync[1] & ~nd_sync[0];

    // synchronise ps2_clk and the host pop request into the clk domain
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync <= '1;
            nd_sync  <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[SYNC_LEN-2:0], ps2_clk};
            nd_sync  <= {nd_sync[0], nextdata_n};
        end
    end

    // count frame bits and capture samples; the stop bit is checked live, never stored
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt    <= 4'd0;
            buffer <= '0;
        end else if (fall) begin
            if (cnt < 4'(BUF_W)) buffer[cnt] <= ps2_data;
            cnt <= (cnt == 4'(PS2_STOP_IDX)) ? 4'd0 : cnt + 4'd1;
        end
    end

    ps2_rx_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .push     (push),
        .din      (buffer[8:1]),
        .pop      (pop),
        .dout     (data),
        .ready    (ready),
        .overflow (overflow)
    );
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx: directed bench for the PS/2 receiver and its scan-code FIFO
module tb_ps2_keyboard_rx;
    import ps2_keyboard_rx_pkg::*;

    logic       clk = 1'b0;
    logic       clrn, ps2_clk, ps2_data, nextdata_n;
    logic [7:0] data;
    logic       ready, overflow;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp5 [5] = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B};

    ps2_keyboard_rx dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic flip, input bit lat);
        logic [10:0] f;
        f = {stop, ~^b ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            #20;
            ps2_clk = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            if (lat && i == 10) begin
                chk("lat_ready", {7'b0, ready}, 8'h01);
                chk("lat_data", data, b);
            end
            ps2_clk = 1'b1;
            #40;
        end
    endtask

    task automatic pop_once(input int hold);
        nextdata_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        nextdata_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clrn = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        nextdata_n = 1'b1;
        #20;
        clrn = 1'b1;
        #1;
        chk("rst_ready", {7'b0, ready}, 8'h00);
        chk("rst_ovf", {7'b0, overflow}, 8'h00);
        chk("rst_data", data, 8'h00);

        send(8'h1C, 1'b1, 1'b0, 1'b1);
        pop_once(3);
        chk("pop1_ready", {7'b0, ready}, 8'h00);

        send(PS2_BREAK, 1'b1, 1'b0, 1'b0);
        send(8'h1C, 1'b1, 1'b0, 1'b0);
        chk("two_head", data, 8'hF0);
        pop_once(3);
        chk("two_second", data, 8'h1C);
        chk("two_ready", {7'b0, ready}, 8'h01);
        pop_once(3);
        chk("two_empty", {7'b0, ready}, 8'h00);

        for (int i = 0; i < 5; i++) send(exp5[i], 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("five_ready", {7'b0, ready}, 8'h01);
            chk("five_data", data, exp5[i]);
            pop_once(3);
        end
        chk("five_empty", {7'b0, ready}, 8'h00);
        chk("five_ovf", {7'b0, overflow}, 8'h00);

        send(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0, 1'b0);
        pop_once(12);
        chk("hold_data", data, 8'h22);
        chk("hold_ready", {7'b0, ready}, 8'h01);
        pop_once(3);
        chk("hold_empty", {7'b0, ready}, 8'h00);

        pop_once(3);
        send(8'h12, 1'b1, 1'b0, 1'b0);
        chk("empty_pop_data", data, 8'h12);
        chk("empty_pop_ready", {7'b0, ready}, 8'h01);
        pop_once(3);
        chk("empty_pop_done", {7'b0, ready}, 8'h00);

        send(8'h55, 1'b0, 1'b0, 1'b0);
        chk("bad_stop", {7'b0, ready}, 8'h00);
        send(8'h66, 1'b1, 1'b1, 1'b0);
`ifdef PS2_PARITY_CHECK_EN
        chk("bad_par_drop", {7'b0, ready}, 8'h00);
`else
        chk("par_ignored", data, 8'h66);
        pop_once(3);
`endif
        send(8'h77, 1'b1, 1'b0, 1'b0);
        chk("after_bad_data", data, 8'h77);
        chk("after_bad_ready", {7'b0, ready}, 8'h01);
        pop_once(3);
        chk("after_bad_empty", {7'b0, ready}, 8'h00);

        for (int i = 1; i <= 7; i++) send(8'(i), 1'b1, 1'b0, 1'b0);
        chk("ovf_before", {7'b0, overflow}, 8'h00);
        send(8'h08, 1'b1, 1'b0, 1'b0);
        chk("ovf_after", {7'b0, overflow}, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            chk("ovf_data", data, 8'(i));
            pop_once(3);
        end
        chk("ovf_empty", {7'b0, ready}, 8'h00);
        chk("ovf_sticky", {7'b0, overflow}, 8'h01);

        for (int i = 0; i < 5; i++) begin
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            #20;
            ps2_clk = 1'b0;
            #50;
            ps2_clk = 1'b1;
            #40;
        end
        clrn = 1'b0;
        #20;
        clrn = 1'b1;
        #1;
        chk("mid_rst_ready", {7'b0, ready}, 8'h00);
        chk("mid_rst_ovf", {7'b0, overflow}, 8'h00);
        chk("mid_rst_data", data, 8'h00);
        send(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("mid_rst_frame", data, 8'h5A);
        chk("mid_rst_frame_rdy", {7'b0, ready}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
